// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ_BURST,
    WRITE_COMMIT
  } mem_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; contents must survive a reset of the responder.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the cache miss/write-through handshake: fixed latency,
// block refill for reads, single-word commit for writes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int WPB    = 4,
  parameter int LAT    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     rw,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     busy,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rdata_valid,
  output logic [$clog2(WPB)-1:0]   word_idx,
  output logic                     data_ready_m
);

  localparam int IDX_W = $clog2(WPB);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  mem_state_t        state, state_next;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  lat_cnt;
  logic [IDX_W-1:0]  burst_cnt;
  logic [DATA_W-1:0] array_rdata;
  logic              accept;
  logic              last_word;
  logic              done;

  assign accept    = (state == IDLE) && req;
  assign last_word = (state == READ_BURST) && (burst_cnt == IDX_W'(WPB - 1));
  assign done      = last_word || (state == WRITE_COMMIT);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:         if (accept) state_next = WAIT;
      WAIT:         if (lat_cnt == '0)
                      state_next = (rw_q == RW_READ) ? READ_BURST : WRITE_COMMIT;
      READ_BURST:   if (last_word) state_next = IDLE;
      WRITE_COMMIT: state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rw_q         <= RW_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt      <= '0;
      burst_cnt    <= '0;
      busy         <= 1'b0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      word_idx     <= '0;
      data_ready_m <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        rw_q      <= rw;
        addr_q    <= addr;
        wdata_q   <= wdata;
        lat_cnt   <= CNT_W'(LAT - 1);
        burst_cnt <= '0;
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      // Burst index wraps back to zero on the last word.
      if (state == READ_BURST) burst_cnt <= burst_cnt + 1'b1;

      // Busy stays high through the completion cycle.
      busy         <= (state_next != IDLE) || done;
      rdata_valid  <= (state == READ_BURST);
      rdata        <= (state == READ_BURST) ? array_rdata : '0;
      word_idx     <= (state == READ_BURST) ? burst_cnt : '0;
      data_ready_m <= done;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (state == WRITE_COMMIT),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr({addr_q[ADDR_W-1:IDX_W], burst_cnt}),
    .rdata(array_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a cycle-timeline model.
module tb_mem_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int WPB    = 4;
  localparam int LAT    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [1:0]  word_idx;
  logic        data_ready_m;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [256];

  mem_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WPB   (WPB),
    .LAT   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rw          (rw),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .word_idx    (word_idx),
    .data_ready_m(data_ready_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_valid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_idx"},   32'(word_idx), 32'd0);
    check({tag, "_ready"}, 32'(data_ready_m), 32'd0);
  endtask

  task automatic present(input logic r, input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; rw = r; addr = a; wdata = d;
  endtask

  // Follows one transaction whose request is already presented before the next
  // rising edge (edge k). Samples on falling edges; j counts edges after k.
  task automatic body(input logic r, input logic [7:0] a, input logic [31:0] d,
                      input bit perturb, input bit hold,
                      input logic nr, input logic [7:0] na, input logic [31:0] nd);
    int   last;
    int   i;
    bit   v;
    logic [7:0] base;
    last = r ? LAT + 1 : LAT + WPB;
    base = a & 8'(~(WPB - 1));
    @(posedge clk);
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      i = j - LAT - 1;
      v = !r && (j >= LAT + 1) && (j <= LAT + WPB);
      check("busy",  32'(busy), 32'd1);
      check("ready", 32'(data_ready_m), 32'(j == last));
      check("valid", 32'(rdata_valid), 32'(v));
      if (v) begin
        check("word_idx", 32'(word_idx), 32'(i));
        check("rdata", rdata, model[int'(8'(int'(base) + i))]);
      end
      if (j == last) begin
        if (r) model[a] = d;
        if (hold) present(nr, na, nd);
        else req = 1'b0;
      end else if (perturb) begin
        req = 1'($urandom); rw = 1'($urandom); addr = 8'($urandom); wdata = $urandom;
      end else if (!hold) begin
        req = 1'b0;
      end
    end
    if (!hold) begin
      @(negedge clk);
      check("idle_busy",  32'(busy), 32'd0);
      check("idle_ready", 32'(data_ready_m), 32'd0);
      check("idle_valid", 32'(rdata_valid), 32'd0);
    end
  endtask

  task automatic run(input logic r, input logic [7:0] a, input logic [31:0] d, input bit perturb);
    present(r, a, d);
    body(r, a, d, perturb, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Starts a transaction, then asserts reset asynchronously during its latency wait.
  task automatic abort_in_wait(input logic r, input logic [7:0] a, input logic [31:0] d,
                               input string tag);
    present(r, a, d);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check({tag, "_busy_before"}, 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero(tag);
    @(negedge clk);
    check_all_zero({tag, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    logic        cr, nr;
    logic [7:0]  ca, na;
    logic [31:0] cd, nd;
    bit          h;

    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Fill the whole array through the write path so the model is fully known.
    for (int a = 0; a < 256; a++) run(1'b1, 8'(a), $urandom, 1'b0);

    run(1'b1, 8'h12, 32'hDEADBEEF, 1'b0);
    for (int a = 0; a < 4; a++) run(1'b1, 8'(8'h10 + a), 32'(32'hA0 + a), 1'b0);
    run(1'b0, 8'h12, 32'h0, 1'b0);

    // Top-of-space block: base 0xFC, fourth word is the one just written.
    run(1'b1, 8'hFF, 32'h55, 1'b0);
    run(1'b0, 8'hFC, 32'h0, 1'b0);

    // Inputs wiggle throughout a read; the block must stream unchanged.
    run(1'b0, 8'h12, 32'h0, 1'b1);

    // Request held high: the next acceptance is the edge after data_ready_m.
    present(1'b0, 8'h10, 32'h0);
    body(1'b0, 8'h10, 32'h0, 1'b0, 1'b1, 1'b1, 8'h30, 32'h1234);
    body(1'b1, 8'h30, 32'h1234, 1'b0, 1'b1, 1'b0, 8'h30, 32'h0);
    body(1'b0, 8'h30, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Reset mid-read: request right after release is accepted on the next edge.
    abort_in_wait(1'b0, 8'h12, 32'h0, "rst_read");
    present(1'b0, 8'h12, 32'h0);
    body(1'b0, 8'h12, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Aborted write must leave the old word in place.
    run(1'b1, 8'h20, 32'h7, 1'b0);
    abort_in_wait(1'b1, 8'h20, 32'h99, "rst_write");
    run(1'b0, 8'h20, 32'h0, 1'b0);

    cr = 1'($urandom); ca = 8'($urandom); cd = $urandom;
    present(cr, ca, cd);
    for (int n = 0; n < 80; n++) begin
      nr = 1'($urandom); na = 8'($urandom); nd = $urandom;
      h  = (n < 79) && ($urandom_range(0, 3) == 0);
      body(cr, ca, cd, 1'($urandom), h, nr, na, nd);
      if (!h && n < 79) present(nr, na, nd);
      cr = nr; ca = na; cd = nd;
    end
    req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
